// File: rtl/ll_head_table_stage.sv
// Head-pointer table stage: looks up a bucket's head pointer and forwards the command downstream.
// Optional LL_HT_STATS_EN adds lookup/hit counters. Writes that race a lookup are bypassed into the result.
module ll_head_table_stage #(
    parameter int KEY_WIDTH    = 32,
    parameter int BUCKET_WIDTH = 8,
    parameter int PTR_WIDTH    = 8,
    parameter int RAM_LATENCY  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [KEY_WIDTH-1:0]    in_key_i,
    input  logic [1:0]              in_opcode_i,
    input  logic [BUCKET_WIDTH-1:0] in_bucket_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [KEY_WIDTH-1:0]    out_key_o,
    output logic [1:0]              out_opcode_o,
    output logic [PTR_WIDTH-1:0]    out_head_ptr_o,
    output logic                    out_head_ptr_val_o,
    input  logic [PTR_WIDTH-1:0]    ht_wr_data_ptr_i,
    input  logic                    ht_wr_data_ptr_val_i,
    input  logic                    ht_wr_en_i,
    input  logic                    clear_run_i,
    output logic                    clear_done_o,
    output logic                    busy_o
`ifdef LL_HT_STATS_EN
    ,
    output logic [31:0]             stat_lookups_o,
    output logic [31:0]             stat_hits_o
`endif
);
    // state | meaning
    // IDLE  | ready for a command or a clear request
    // READ  | waiting RAM_LATENCY cycles for the head RAM
    // HOLD  | result presented downstream until accepted
    // CLEAR | zeroing the table, one address per cycle
    typedef enum logic [1:0] {IDLE, READ, HOLD, CLEAR} state_t;

    localparam int         DEPTH    = 2 ** BUCKET_WIDTH;
    localparam int         WORD_W   = PTR_WIDTH + 1;
    localparam logic [1:0] LAT_LOAD = 2'(RAM_LATENCY - 1);

    state_t                  state;
    logic [BUCKET_WIDTH-1:0] lat_bucket;
    logic [BUCKET_WIDTH-1:0] wr_bucket;
    logic [BUCKET_WIDTH-1:0] clr_addr;
    logic [1:0]              lat_cnt;
    logic                    byp_armed;
    logic [WORD_W-1:0]       byp_word;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] rd_pipe [RAM_LATENCY];

    logic [WORD_W-1:0]       wr_word;
    logic [BUCKET_WIDTH-1:0] cmp_bucket;
    logic                    wr_hit;
    logic [WORD_W-1:0]       cap_word;
    logic                    ram_we;
    logic [BUCKET_WIDTH-1:0] ram_addr;
    logic [WORD_W-1:0]       ram_wdata;

    assign wr_word    = {ht_wr_data_ptr_val_i, ht_wr_data_ptr_i};
    assign cmp_bucket = (state == IDLE) ? in_bucket_i : lat_bucket;
    assign wr_hit     = ht_wr_en_i && (wr_bucket == cmp_bucket);
    // A write landing in the capture cycle is newer than anything the bypass register holds.
    assign cap_word   = wr_hit ? wr_word : (byp_armed ? byp_word : rd_pipe[RAM_LATENCY-1]);

    assign ram_we    = (state == CLEAR) || ht_wr_en_i;
    assign ram_addr  = (state == CLEAR) ? clr_addr : wr_bucket;
    assign ram_wdata = (state == CLEAR) ? '0 : wr_word;

    assign in_ready_o = (state == IDLE) && !clear_run_i;
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        rd_pipe[0] <= mem[in_bucket_i];
        for (int i = 1; i < RAM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state              <= IDLE;
            lat_bucket         <= '0;
            wr_bucket          <= '0;
            clr_addr           <= '0;
            lat_cnt            <= '0;
            byp_armed          <= 1'b0;
            byp_word           <= '0;
            out_valid_o        <= 1'b0;
            out_key_o          <= '0;
            out_opcode_o       <= '0;
            out_head_ptr_o     <= '0;
            out_head_ptr_val_o <= 1'b0;
            clear_done_o       <= 1'b0;
        end else begin
            clear_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_run_i) begin
                        clr_addr <= '0;
                        state    <= CLEAR;
                    end else if (in_valid_i) begin
                        out_key_o    <= in_key_i;
                        out_opcode_o <= in_opcode_i;
                        lat_bucket   <= in_bucket_i;
                        lat_cnt      <= LAT_LOAD;
                        byp_armed    <= wr_hit;
                        byp_word     <= wr_word;
                        state        <= READ;
                    end
                end
                READ: begin
                    if (wr_hit) begin
                        byp_armed <= 1'b1;
                        byp_word  <= wr_word;
                    end
                    if (lat_cnt == 2'd0) begin
                        out_valid_o        <= 1'b1;
                        out_head_ptr_o     <= cap_word[PTR_WIDTH-1:0];
                        out_head_ptr_val_o <= cap_word[PTR_WIDTH];
                        state              <= HOLD;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        wr_bucket   <= lat_bucket;
                        state       <= IDLE;
                    end else if (wr_hit) begin
                        out_head_ptr_o     <= ht_wr_data_ptr_i;
                        out_head_ptr_val_o <= ht_wr_data_ptr_val_i;
                    end
                end
                CLEAR: begin
                    if (clear_run_i) begin
                        clr_addr <= '0;
                    end else if (clr_addr == '1) begin
                        clear_done_o <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LL_HT_STATS_EN
    logic out_hs;
    assign out_hs = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_lookups_o <= '0;
            stat_hits_o    <= '0;
        end else if (clear_run_i) begin
            stat_lookups_o <= '0;
            stat_hits_o    <= '0;
        end else if (out_hs) begin
            if (stat_lookups_o != '1) stat_lookups_o <= stat_lookups_o + 32'd1;
            if (out_head_ptr_val_o && (stat_hits_o != '1)) stat_hits_o <= stat_hits_o + 32'd1;
        end
    end
`endif

endmodule
